// File: rtl/riscv_types.sv
// Shared fetch-side RISC-V definitions: canonical NOP encoding and fetch FSM states.
package riscv_types;

  localparam logic [31:0] RISCV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {RESET, RUN, DRAIN} fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, instr} words: zero-latency head, push and pop in the same cycle even when full.
// Flush empties it on the next edge; a push is dropped only when full without a same-cycle pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [2*WIDTH-1:0]         wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [2*WIDTH-1:0]         rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic               do_push;
  logic               do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential PC requests, in-order responses into a prefetch buffer, one instruction per cycle to decode.
// Grant to instr_out is two edges with a 1-cycle memory; stall holds the output while prefetch fills up to DEPTH.
module instr_fetch
  import riscv_types::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int               DEPTH    = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             stall_in,
  input  logic             redirect_in,
  input  logic [WIDTH-1:0] redirect_pc_in,
  output logic             imem_req_out,
  output logic [WIDTH-1:0] imem_addr_out,
  input  logic             imem_gnt_in,
  input  logic             imem_rvalid_in,
  input  logic [WIDTH-1:0] imem_rdata_in,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             valid_out
);

  localparam int               CW  = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] NOP = WIDTH'(RISCV_NOP);

  fetch_state_t       state;
  logic [WIDTH-1:0]   fetch_pc;
  logic [WIDTH-1:0]   resp_pc;
  logic [WIDTH-1:0]   redirect_tgt;
  logic [CW-1:0]      out_cnt;
  logic [CW-1:0]      kill_cnt;
  logic [CW-1:0]      out_cnt_nxt;
  logic [CW-1:0]      kill_cnt_nxt;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2*WIDTH-1:0] head;
  logic               xfer;
  logic               rsp;
  logic               push;
  logic               pop;

  assign redirect_tgt = redirect_pc_in & ~WIDTH'(3);
  assign imem_addr_out = fetch_pc;

  // A same-cycle pop frees a slot, which keeps the stream at one instruction per cycle.
  assign pop          = !stall_in && !redirect_in && !fifo_empty;
  assign imem_req_out = (state != RESET) &&
                        (int'(out_cnt) + int'(fifo_count) - int'(pop) < DEPTH);
  assign xfer         = imem_req_out && imem_gnt_in;
  assign rsp          = imem_rvalid_in && (out_cnt != '0);
  assign push         = rsp && (kill_cnt == '0) && !redirect_in && (!fifo_full || pop);

  // On redirect everything still in flight after this edge is stale, including a same-cycle grant.
  assign out_cnt_nxt  = out_cnt + CW'(xfer) - CW'(rsp);
  assign kill_cnt_nxt = redirect_in ? out_cnt_nxt
                                    : kill_cnt - CW'(rsp && (kill_cnt != '0));

  fetch_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk_in),
    .rst_n(rst_n_in),
    .push (push),
    .wdata({resp_pc, imem_rdata_in}),
    .pop  (pop),
    .flush(redirect_in),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= RESET;
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      out_cnt   <= '0;
      kill_cnt  <= '0;
      instr_out <= NOP;
      pc_out    <= RESET_PC;
      valid_out <= 1'b0;
    end else begin
      out_cnt  <= out_cnt_nxt;
      kill_cnt <= kill_cnt_nxt;
      case (state)
        RESET:   state <= RUN;
        default: state <= (kill_cnt_nxt != '0) ? DRAIN : RUN;
      endcase

      // resp_pc tracks the PC of the next live response; killed responses leave it alone.
      if (redirect_in) begin
        fetch_pc <= redirect_tgt;
        resp_pc  <= redirect_tgt;
      end else begin
        if (xfer) fetch_pc <= fetch_pc + WIDTH'(4);
        if (push) resp_pc  <= resp_pc + WIDTH'(4);
      end

      if (redirect_in || (!stall_in && fifo_empty)) begin
        instr_out <= NOP;
        valid_out <= 1'b0;
      end else if (!stall_in) begin
        instr_out <= head[WIDTH-1:0];
        pc_out    <= head[2*WIDTH-1:WIDTH];
        valid_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: behavioural in-order memory plus a fetch-stream reference model.
module tb_instr_fetch;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          M_NONE  = 0;
  localparam int          M_LOAD  = 1;
  localparam int          M_HOLD  = 2;
  localparam int          M_REDIR = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        mem_hold;

  int          n_cmp;
  int          n_bad;
  ent_t        exp_q[$];
  logic [31:0] mq[$];
  logic [31:0] exp_pc;
  logic [31:0] last_pc;
  logic [31:0] last_instr;
  logic        last_valid;
  int          outstanding;
  int          prev_mode;
  bit          ok;

  instr_fetch dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .stall_in      (stall),
    .redirect_in   (redirect),
    .redirect_pc_in(redirect_pc),
    .imem_req_out  (req),
    .imem_addr_out (addr),
    .imem_gnt_in   (gnt),
    .imem_rvalid_in(rvalid),
    .imem_rdata_in (rdata),
    .instr_out     (instr),
    .pc_out        (pc),
    .valid_out     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // In-order memory: responds at least one cycle after the grant, paused by mem_hold.
  initial begin
    rvalid = 1'b0;
    rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_hold && mq.size() > 0) begin
        rvalid = 1'b1;
        rdata  = instr_of(mq.pop_front());
      end else begin
        rvalid = 1'b0;
      end
      @(negedge clk);
      if (!rst_n) mq.delete();
      else if (req && gnt) mq.push_back(addr);
    end
  end

  // Reference model: expected entries are queued at grant time and popped when the output loads.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_pc      = 32'h0;
      last_pc     = 32'h0;
      last_instr  = NOP;
      last_valid  = 1'b0;
      outstanding = 0;
      prev_mode   = M_NONE;
    end else begin
      case (prev_mode)
        M_REDIR: begin
          chk("redirect_bubble_valid", 64'(valid), 64'(0));
          chk("redirect_bubble_nop", 64'(instr), 64'(NOP));
          last_valid = 1'b0;
          last_instr = NOP;
        end
        M_HOLD: begin
          chk("hold_pc", 64'(pc), 64'(last_pc));
          chk("hold_instr", 64'(instr), 64'(last_instr));
          chk("hold_valid", 64'(valid), 64'(last_valid));
        end
        M_LOAD: begin
          if (valid) begin
            if (exp_q.size() == 0) begin
              chk("valid_with_nothing_expected", 64'(valid), 64'(0));
            end else begin
              ent_t e;
              e = exp_q.pop_front();
              chk("sb_pc", 64'(pc), 64'(e.pc));
              chk("sb_instr", 64'(instr), 64'(e.instr));
              last_pc    = e.pc;
              last_instr = e.instr;
              last_valid = 1'b1;
            end
          end else begin
            chk("bubble_pc", 64'(pc), 64'(last_pc));
            chk("bubble_nop", 64'(instr), 64'(NOP));
            last_valid = 1'b0;
            last_instr = NOP;
          end
        end
        default: ;
      endcase
      if (rvalid) outstanding--;
      if (req && gnt) begin
        chk("req_addr", 64'(addr), 64'(exp_pc));
        exp_q.push_back({exp_pc, instr_of(exp_pc)});
        exp_pc = exp_pc + 32'd4;
        outstanding++;
      end
      if (stall) chk("outstanding_le_2", 64'(outstanding <= 2), 64'(1));
      if (redirect) begin
        exp_q.delete();
        exp_pc    = redirect_pc & ~32'h3;
        prev_mode = M_REDIR;
      end else begin
        prev_mode = stall ? M_HOLD : M_LOAD;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    gnt         = 1'b1;
    mem_hold    = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_req", 64'(req), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_instr", 64'(instr), 64'(NOP));
    chk("rst_pc", 64'(pc), 64'(0));

    // Release, then first valid instruction by the 4th edge.
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state_no_req", 64'(req), 64'(0));
    tick();
    @(negedge clk);
    chk("run_req", 64'(req), 64'(1));
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("first_valid", 64'(valid), 64'(1));
    chk("first_pc", 64'(pc), 64'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      chk("stream_valid", 64'(valid), 64'(1));
    end

    // Stall mid-stream for 5 cycles, then a gapless restart.
    tick();
    stall = 1'b1;
    repeat (5) tick();
    stall = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("resume_valid", 64'(valid), 64'(1));
      tick();
    end

    // Grant withheld for 3 cycles: address stable, buffer runs dry.
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gnt_low_req", 64'(req), 64'(1));
      chk("gnt_low_addr_stable", 64'(addr), 64'(exp_pc));
      tick();
    end
    gnt = 1'b1;
    @(negedge clk);
    chk("gnt_low_bubble_valid", 64'(valid), 64'(0));
    chk("gnt_low_bubble_nop", 64'(instr), 64'(NOP));
    repeat (3) tick();

    // Redirect together with stall: bubble wins, redirect taken.
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    repeat (2) tick();
    stall = 1'b0;
    wait_valid(20, ok);
    chk("redir_stall_found", 64'(ok), 64'(1));
    chk("redir_stall_pc", 64'(pc), 64'(32'h200));
    repeat (4) tick();

    // Two requests in flight when redirecting to an unaligned target.
    mem_hold = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("inflight_before_redirect", 64'(outstanding), 64'(2));
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    repeat (2) tick();
    mem_hold = 1'b0;
    wait_valid(20, ok);
    chk("redir_found", 64'(ok), 64'(1));
    chk("redir_pc", 64'(pc), 64'(32'h100));
    repeat (3) tick();

    // PC wrap-around at the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (req && gnt) ok = 1'b1;
    end
    chk("wrap_first_grant", 64'(ok), 64'(1));
    chk("wrap_first_addr", 64'(addr), 64'(32'hFFFF_FFFC));
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (req && gnt) ok = 1'b1;
    end
    chk("wrap_second_grant", 64'(ok), 64'(1));
    chk("wrap_second_addr", 64'(addr), 64'(32'h0));
    repeat (5) tick();

    // Asynchronous reset mid-stream, then a clean restart from RESET_PC.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(valid), 64'(0));
    chk("midrst_req", 64'(req), 64'(0));
    chk("midrst_pc", 64'(pc), 64'(0));
    chk("midrst_addr", 64'(addr), 64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    wait_valid(20, ok);
    chk("restart_found", 64'(ok), 64'(1));
    chk("restart_pc", 64'(pc), 64'(0));
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters, one per line:
- WIDTH, 32, data/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, prefetch buffer entries.

REQ-002 Ports, one per line:
- clk_in  in  1  clock; all state on rising edge.
- rst_n_in  in  1  reset, asynchronous assert, active-low.
- stall_in  in  1  hold the fetch output (hazard unit).
- redirect_in  in  1  taken branch/jump.
- redirect_pc_in  in  WIDTH  redirect target.
- imem_req_out  out  1  instruction memory request.
- imem_addr_out  out  WIDTH  request address.
- imem_gnt_in  in  1  request accepted this cycle.
- imem_rvalid_in  in  1  response valid.
- imem_rdata_in  in  WIDTH  response instruction.
- instr_out  out  WIDTH  instruction to the decode stage.
- pc_out  out  WIDTH  PC of instr_out.
- valid_out  out  1  instr_out is a real instruction.

Function
REQ-003 The block SHALL hold a fetch PC; a request transfers only on a cycle with imem_req_out=1 and imem_gnt_in=1, then the PC advances by 4 (modulo 2^WIDTH, wrap-around allowed).
REQ-004 imem_addr_out SHALL equal the fetch PC and SHALL stay stable while imem_req_out=1 and imem_gnt_in=0.
REQ-005 imem_req_out SHALL be 1 only when outstanding requests plus buffered entries < DEPTH; with DEPTH=2 at most 2 requests are in flight.
REQ-006 Responses SHALL arrive in order, at least 1 cycle after the grant; each non-killed response SHALL be written to the prefetch buffer together with its PC.
REQ-007 With stall_in=0, the output register SHALL load the buffer head (valid_out=1) or, if the buffer is empty, a bubble: instr_out=NOP 32'h0000_0013, valid_out=0, pc_out unchanged.
REQ-008 With stall_in=1, instr_out, pc_out and valid_out SHALL hold, and buffer fill and requests SHALL continue up to the REQ-005 limit.
REQ-009 When redirect_in=1, on the next edge the block SHALL:
- set the fetch PC to {redirect_pc_in[WIDTH-1:2],2'b00};
- flush the buffer;
- load a bubble into the output.
REQ-010 redirect_in SHALL take priority over stall_in and over a same-cycle response or grant.
REQ-011 On redirect, the kill count SHALL be set to the in-flight requests, including one granted in the same cycle; while it is non-zero, each response SHALL be discarded and decrement it.
REQ-012 FSM states:
- RESET: one cycle after reset release, no request;
- RUN: normal operation;
- DRAIN: kill count non-zero.
REQ-013 FSM transitions:
- RESET->RUN unconditionally;
- RUN->DRAIN on redirect with requests in flight;
- DRAIN->RUN when the kill count reaches 0.
REQ-014 In DRAIN, requests to the new PC SHALL still be issued, subject to REQ-005 counting both killed and live requests.
REQ-015 Buffer full with a simultaneous pop and push SHALL perform both in the same cycle, with no loss and no duplication.

Reset
REQ-016 While rst_n_in=0, the block SHALL set:
- fetch PC=RESET_PC, imem_addr_out=RESET_PC;
- imem_req_out=0, valid_out=0;
- instr_out=NOP, pc_out=RESET_PC;
- buffer empty, kill count 0, state RESET.
REQ-017 Reset asserted mid-transaction SHALL abandon outstanding requests; responses arriving after release SHALL be ignored only if the memory issues none. Memory reset is shared, so none are issued.

Structure
REQ-018 RISCV_NOP constant and the fetch_state_t enum (RESET, RUN, DRAIN) SHALL live in riscv_types.
REQ-019 The prefetch buffer SHALL be a sub-module fetch_fifo (parameters WIDTH, DEPTH; push, pop, flush, full, empty, count; data = {pc, instr}).

Verification
REQ-020 Reset release, imem_gnt_in=1 always, 1-cycle rvalid -> addresses 0,4,8,... are requested. First valid_out=1 is pc_out=0 by the 4th edge; thereafter one instruction per cycle.
REQ-021 stall_in=1 for 5 cycles mid-stream -> instr_out/pc_out are held; at most 2 requests are outstanding; the stream resumes with no gap or duplicate PC.
REQ-022 redirect_in=1 to 32'h0000_0103 with 2 requests in flight -> the next request is 32'h0000_0100; both old responses are dropped; the next valid pc_out is 32'h100.
REQ-023 redirect_in and stall_in both high -> a bubble (valid_out=0, instr_out=32'h13) is loaded; the redirect is taken.
REQ-024 imem_gnt_in low for 3 cycles -> imem_addr_out is stable throughout; with no instruction available, bubbles are output.
REQ-025 Fetch PC at 32'hFFFF_FFFC -> the next request is to 32'h0000_0000.
